// File: rtl/lamp_monitor.sv
// Independent conflict/timing monitor for the six active-low intersection lamps.
// Latches the first illegal aspect, order or dwell violation as a sticky coded fault.
module lamp_monitor #(
    parameter int unsigned YELLOW_CYCLES    = 6,
    parameter int unsigned MIN_GREEN_CYCLES = 31,
    parameter int unsigned STARTUP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       NorthRed,
    input  logic       NorthYellow,
    input  logic       NorthGreen,
    input  logic       EastRed,
    input  logic       EastYellow,
    input  logic       EastGreen,
    input  logic       fault_clear,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] aspect,
    output logic [7:0] dwell
);

    localparam int unsigned DwellW = 8;
    localparam int unsigned GraceW = 8;
    localparam int unsigned CodeW  = 3;

    localparam logic [DwellW-1:0] DwellMax    = DwellW'(255);
    localparam logic [DwellW-1:0] YellowLen   = DwellW'(YELLOW_CYCLES);
    localparam logic [DwellW-1:0] MinGreenLen = DwellW'(MIN_GREEN_CYCLES);
    localparam logic [GraceW-1:0] GraceLen    = GraceW'(STARTUP_CYCLES);

    localparam logic [1:0] AspNorth   = 2'd0;
    localparam logic [1:0] AspEast    = 2'd1;
    localparam logic [1:0] AspYellow  = 2'd2;
    localparam logic [1:0] AspUnknown = 2'd3;

    localparam logic [CodeW-1:0] CodeNone       = CodeW'(0);
    localparam logic [CodeW-1:0] CodeIllegal    = CodeW'(1);
    localparam logic [CodeW-1:0] CodeTransition = CodeW'(2);
    localparam logic [CodeW-1:0] CodeYellowShort = CodeW'(3);
    localparam logic [CodeW-1:0] CodeYellowLong = CodeW'(4);
    localparam logic [CodeW-1:0] CodeGreenShort = CodeW'(5);

    typedef enum logic [2:0] {
        INIT   = 3'd0,
        TRK_NG = 3'd1,
        TRK_Y  = 3'd2,
        TRK_EG = 3'd3,
        FAULT  = 3'd4
    } stateT;

    stateT              state;
    stateT              stateNext;
    logic [CodeW-1:0]   codeNext;
    logic [CodeW-1:0]   violation;
    logic [DwellW-1:0]  dwellNext;
    logic [GraceW-1:0]  grace;
    logic [GraceW-1:0]  graceNext;
    logic               partial;
    logic               partialNext;
    logic               prevGreen;      // 0: north green preceded yellow, 1: east
    logic               prevGreenNext;
    logic               restartDwell;
    logic [5:0]         lamps;
    logic [1:0]         sampleAspect;
    logic               sampleIsGreen;
    logic               sampleIsEast;

    // Decode the raw active-low lamp pattern into an aspect
    always_comb begin
        lamps = {NorthRed, NorthYellow, NorthGreen, EastRed, EastYellow, EastGreen};
        case (lamps)
            6'b110011: sampleAspect = AspNorth;
            6'b011110: sampleAspect = AspEast;
            6'b101101: sampleAspect = AspYellow;
            default:   sampleAspect = AspUnknown;
        endcase
        sampleIsGreen = (sampleAspect == AspNorth) || (sampleAspect == AspEast);
        sampleIsEast  = (sampleAspect == AspEast);
    end

    // Next-state, violation detection and dwell bookkeeping
    always_comb begin
        stateNext     = state;
        codeNext      = fault_code;
        graceNext     = grace;
        partialNext   = partial;
        prevGreenNext = prevGreen;
        violation     = CodeNone;
        restartDwell  = 1'b0;

        case (state)
            INIT: begin
                if (sampleAspect == AspUnknown && grace >= GraceLen) begin
                    violation = CodeIllegal;
                end else begin
                    if (grace < GraceLen) begin
                        graceNext = grace + GraceW'(1);
                    end
                    if (sampleIsGreen) begin
                        stateNext    = sampleIsEast ? TRK_EG : TRK_NG;
                        partialNext  = 1'b1;
                        restartDwell = 1'b1;
                    end
                end
            end

            TRK_NG, TRK_EG: begin
                if (sampleAspect == AspUnknown) begin
                    violation = CodeIllegal;
                end else if (sampleAspect == AspYellow) begin
                    if (!partial && dwell < MinGreenLen) begin
                        violation = CodeGreenShort;
                    end else begin
                        stateNext     = TRK_Y;
                        prevGreenNext = (state == TRK_EG);
                    end
                end else if (sampleIsEast != (state == TRK_EG)) begin
                    violation = CodeTransition;
                end
            end

            TRK_Y: begin
                if (sampleAspect == AspUnknown) begin
                    violation = CodeIllegal;
                end else if (sampleAspect == AspYellow) begin
                    if (dwell == YellowLen) begin
                        violation = CodeYellowLong;
                    end
                end else if (sampleIsEast == prevGreen) begin
                    violation = CodeTransition;
                end else if (dwell < YellowLen) begin
                    violation = CodeYellowShort;
                end else begin
                    stateNext    = sampleIsEast ? TRK_EG : TRK_NG;
                    partialNext  = 1'b0;
                    restartDwell = 1'b1;
                end
            end

            FAULT: begin
                stateNext = FAULT;
            end

            default: begin
                stateNext = INIT;
            end
        endcase

        if (violation != CodeNone) begin
            stateNext = FAULT;
            codeNext  = violation;
        end

        // Maintenance acknowledge outranks anything detected on the same sample
        if (fault_clear) begin
            stateNext    = INIT;
            codeNext     = CodeNone;
            graceNext    = '0;
            partialNext  = 1'b0;
            restartDwell = 1'b0;
        end

        if (restartDwell || sampleAspect != aspect) begin
            dwellNext = DwellW'(1);
        end else if (dwell == DwellMax) begin
            dwellNext = dwell;
        end else begin
            dwellNext = dwell + DwellW'(1);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= INIT;
            fault      <= 1'b0;
            fault_code <= CodeNone;
            aspect     <= AspUnknown;
            dwell      <= '0;
            grace      <= '0;
            partial    <= 1'b0;
            prevGreen  <= 1'b0;
        end else begin
            state      <= stateNext;
            fault      <= (stateNext == FAULT);
            fault_code <= codeNext;
            aspect     <= sampleAspect;
            dwell      <= dwellNext;
            grace      <= graceNext;
            partial    <= partialNext;
            prevGreen  <= prevGreenNext;
        end
    end

endmodule

// File: tb/tb_lamp_monitor.sv
// Directed bench for lamp_monitor: run-based behavioural model checked every cycle,
// plus literal expectations after each scenario.
module tb_lamp_monitor;

    localparam int YCYC   = 6;
    localparam int MING   = 31;
    localparam int GRACE  = 2;

    localparam logic [5:0] LNG   = 6'b110011;
    localparam logic [5:0] LEG   = 6'b011110;
    localparam logic [5:0] LY    = 6'b101101;
    localparam logic [5:0] LDARK = 6'b111111;
    localparam logic [5:0] LBAD  = 6'b110010;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       NorthRed = 1'b1, NorthYellow = 1'b1, NorthGreen = 1'b1;
    logic       EastRed = 1'b1, EastYellow = 1'b1, EastGreen = 1'b1;
    logic       fault_clear = 1'b0;
    logic       fault;
    logic [2:0] fault_code;
    logic [1:0] aspect;
    logic [7:0] dwell;

    int nChecks = 0;
    int nPass   = 0;
    bit cmpEn   = 0;

    // model state: tracked aspect/run length, sync status, last green before yellow
    int mAspect = 3, mDwell = 0, mCode = 0, mPrev = 0, mSince = 0;
    bit mFault = 0, mTracking = 0, mPartial = 0;

    lamp_monitor #(
        .YELLOW_CYCLES(YCYC), .MIN_GREEN_CYCLES(MING), .STARTUP_CYCLES(GRACE)
    ) dut (
        .clk(clk), .reset(reset),
        .NorthRed(NorthRed), .NorthYellow(NorthYellow), .NorthGreen(NorthGreen),
        .EastRed(EastRed), .EastYellow(EastYellow), .EastGreen(EastGreen),
        .fault_clear(fault_clear),
        .fault(fault), .fault_code(fault_code), .aspect(aspect), .dwell(dwell)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    task automatic modelStep(input logic [5:0] l, input logic clr, input logic rst);
        int a;
        int nd;
        int viol;
        a = (l == LNG) ? 0 : (l == LEG) ? 1 : (l == LY) ? 2 : 3;
        if (rst) begin
            mFault = 0; mCode = 0; mAspect = 3; mDwell = 0;
            mTracking = 0; mPartial = 0; mSince = 0; mPrev = 0;
            return;
        end
        nd = (a == mAspect) ? ((mDwell < 255) ? mDwell + 1 : 255) : 1;
        viol = 0;
        if (clr) begin
            mFault = 0; mCode = 0; mTracking = 0; mSince = 0; mPartial = 0;
        end else if (!mFault) begin
            if (!mTracking) begin
                if (a == 3 && mSince >= GRACE) viol = 1;
                else begin
                    if (mSince < GRACE) mSince++;
                    if (a < 2) begin mTracking = 1; mPartial = 1; nd = 1; end
                end
            end else if (a == 3) begin
                viol = 1;
            end else if (mAspect < 2) begin
                if (a == 2) begin
                    if (!mPartial && mDwell < MING) viol = 5;
                    else mPrev = mAspect;
                end else if (a != mAspect) viol = 2;
            end else begin
                if (a == 2) begin
                    if (mDwell == YCYC) viol = 4;
                end else if (a == mPrev) viol = 2;
                else if (mDwell < YCYC) viol = 3;
                else begin mPartial = 0; nd = 1; end
            end
        end
        if (viol != 0) begin mFault = 1; mCode = viol; mTracking = 0; end
        mAspect = a;
        mDwell  = nd;
    endtask

    task automatic step(input logic [5:0] l, input logic clr, input logic rst);
        {NorthRed, NorthYellow, NorthGreen, EastRed, EastYellow, EastGreen} = l;
        fault_clear = clr;
        reset = rst;
        @(posedge clk);
        modelStep(l, clr, rst);
        @(negedge clk);
        #1;
    endtask

    task automatic run(input logic [5:0] l, input int n);
        for (int i = 0; i < n; i++) step(l, 1'b0, 1'b0);
    endtask

    task automatic doReset();
        step(LDARK, 1'b0, 1'b1);
        step(LDARK, 1'b0, 1'b1);
    endtask

    task automatic lit(input string name, input int f, input int c, input int a, input int d);
        chk({name, ".fault"}, int'(fault), f);
        chk({name, ".code"}, int'(fault_code), c);
        if (a >= 0) chk({name, ".aspect"}, int'(aspect), a);
        if (d >= 0) chk({name, ".dwell"}, int'(dwell), d);
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmpEn) begin
            chk("model.fault", int'(fault), int'(mFault));
            chk("model.code", int'(fault_code), mCode);
            chk("model.aspect", int'(aspect), mAspect);
            chk("model.dwell", int'(dwell), mDwell);
        end
    end

    initial begin
        doReset();
        cmpEn = 1;
        lit("reset", 0, 0, 3, 0);

        // legal full cycle
        run(LNG, 40); run(LY, 6); run(LEG, 31); run(LY, 6); run(LNG, 31);
        lit("legal", 0, 0, 0, 31);

        // dwell saturation
        run(LNG, 300);
        lit("sat", 0, 0, 0, 255);

        // yellow short, then sticky
        doReset();
        run(LNG, 40); run(LY, 5); run(LEG, 1);
        lit("yshort", 1, 3, 1, 1);
        run(LNG, 5); run(LDARK, 3);
        lit("sticky", 1, 3, 3, 3);

        // yellow long on 7th yellow sample
        doReset();
        run(LNG, 40); run(LY, 6);
        lit("y6", 0, 0, 2, 6);
        run(LY, 1);
        lit("ylong", 1, 4, 2, 7);

        // same green after yellow
        doReset();
        run(LNG, 40); run(LY, 6); run(LNG, 1);
        lit("samegreen", 1, 2, 0, 1);

        // green short once synchronised
        doReset();
        run(LNG, 40); run(LY, 6); run(LEG, 10); run(LY, 1);
        lit("gshort", 1, 5, 2, 1);
        doReset();
        run(LNG, 40); run(LY, 6); run(LEG, 31); run(LY, 1);
        lit("gok", 0, 0, 2, 1);

        // startup grace on all-dark, then illegal while tracking
        doReset();
        run(LDARK, 2);
        lit("grace", 0, 0, 3, 2);
        run(LDARK, 1);
        lit("dark3", 1, 1, 3, 3);
        step(LDARK, 1'b1, 1'b0);
        lit("clear", 0, 0, 3, -1);
        run(LNG, 5); run(LBAD, 1);
        lit("dualgreen", 1, 1, 3, 1);

        // clear beats a concurrent violation
        step(LBAD, 1'b1, 1'b0);
        lit("clrbeats", 0, 0, 3, 2);
        run(LBAD, 2);
        lit("regrace", 0, 0, 3, 4);

        // reset during yellow tracking, and reset over clear
        run(LNG, 40); run(LY, 3);
        lit("midy", 0, 0, 2, 3);
        step(LY, 1'b0, 1'b1);
        lit("rsty", 0, 0, 3, 0);
        run(LNG, 2); run(LBAD, 1);
        step(LBAD, 1'b1, 1'b1);
        lit("rstclr", 0, 0, 3, 0);

        cmpEn = 0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
